// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/control block.
package hazard_pkg;

  // Control FSM: normal issue, halt drain, terminal halt.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  // Cycles from halt acceptance until is_halted (ecall walks EX, MEM, WB).
  localparam int DRAIN_CYCLES_DEF = 3;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for hazard statistics.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;

  // Increment on events unless frozen or already saturated at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && !freeze && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall, mispredict flush and ecall-halt drain control for the
// 5-stage core. Optional statistics counters are built when HAZARD_STATS_EN
// is defined; otherwise the stall_cnt/flush_cnt ports do not exist.
// Handshake-free block: every output is a per-cycle enable/kill qualifier
// sampled by the pipeline registers on the next rising edge.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_is_ecall,
  input  logic       id_halt_cond,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic       ex_mispredict,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       is_halted,
  output logic [1:0] dbg_state
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int          DW         = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  hz_state_e     state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          load_use;
  logic          halt_req;

  // Load in EX whose result the ID instruction needs this cycle.
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                (id_use_rs2 && (id_rs2 == id_ex_rd)));
  end

  assign halt_req = id_is_ecall && id_halt_cond;

  // State and drain countdown registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state: halt is accepted only when no higher-priority event is present.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (!ex_mispredict && !load_use && halt_req) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = HALTED;
        else               drain_d = drain_q - DRAIN_ONE;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Pipeline control outputs; reset forces a safe frozen, bubbling pipe.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    is_halted    = 1'b0;
    if (reset_n) begin
      case (state_q)
        RUN: begin
          if (ex_mispredict) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
          end else if (halt_req) begin
            // ecall moves on to EX; the younger fetch is killed and PC held.
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b0;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
        HALTED:  is_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

`ifdef HAZARD_STATS_EN
  logic stall_inc, flush_inc, stats_freeze;

  assign stall_inc    = (state_q == RUN) && load_use && !ex_mispredict;
  assign flush_inc    = (state_q == RUN) && ex_mispredict;
  assign stats_freeze = (state_q == HALTED);

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .freeze  (stats_freeze),
    .count   (stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .freeze  (stats_freeze),
    .count   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a cycle-level reference model.
// Builds with or without HAZARD_STATS_EN.
module tb_hazard_control_unit;

  localparam int DC = 3;
`ifdef HAZARD_STATS_EN
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_is_ecall = 0, id_halt_cond = 0;
  logic id_ex_mem_read = 0, ex_mispredict = 0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
  logic [1:0] dbg_state;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_control_unit #(
    .DRAIN_CYCLES (DC)
`ifdef HAZARD_STATS_EN
    , .CNT_W (CW)
`endif
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_is_ecall    (id_is_ecall),
    .id_halt_cond   (id_halt_cond),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .ex_mispredict  (ex_mispredict),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .is_halted      (is_halted),
    .dbg_state      (dbg_state)
`ifdef HAZARD_STATS_EN
    , .stall_cnt    (stall_cnt)
    , .flush_cnt    (flush_cnt)
`endif
  );

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];  // expected {pc_write,if_id_write,if_id_flush,id_ex_bubble,is_halted}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // age < 0: running; otherwise edges elapsed since the halt was accepted.
  int age = -1;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic model_load_use();
    return id_ex_mem_read && (id_ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age     <= -1;
      m_stall <= 0;
      m_flush <= 0;
    end else if (age < 0) begin
      if (ex_mispredict)                   m_flush <= m_flush + 1;
      else if (model_load_use())           m_stall <= m_stall + 1;
      else if (id_is_ecall && id_halt_cond) age <= 0;
    end else if (age < DC) begin
      age <= age + 1;
    end
  end

  function automatic logic [4:0] model_outputs();
    if (!reset_n)                         return 5'b00010;
    if (age >= DC)                        return 5'b00011;
    if (age >= 0)                         return 5'b00010;
    if (ex_mispredict)                    return 5'b11110;
    if (model_load_use())                 return 5'b00010;
    if (id_is_ecall && id_halt_cond)      return 5'b01100;
    return 5'b11000;
  endfunction

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] a;
    exp_q.push_back(model_outputs());
    e = exp_q.pop_front();
    a = {pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted};
    chk("cycle_ctrl", {27'd0, a}, {27'd0, e});
`ifdef HAZARD_STATS_EN
    chk("cycle_stall_cnt", 32'(stall_cnt), 32'((m_stall > CNT_MAX) ? CNT_MAX : m_stall));
    chk("cycle_flush_cnt", 32'(flush_cnt), 32'((m_flush > CNT_MAX) ? CNT_MAX : m_flush));
`endif
  end

  // ---------------- driver tasks ----------------
  // Waits past a rising edge, applies one ID/EX vector, returns just after the falling edge.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic ecall, input logic halt,
                       input logic [4:0] exrd, input logic mr, input logic misp);
    @(posedge clk);
    #1;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_is_ecall = ecall; id_halt_cond = halt; id_ex_rd = exrd;
    id_ex_mem_read = mr; ex_mispredict = misp;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_pc_write", 32'(pc_write), 32'd0);
    chk("reset_bubble", 32'(id_ex_bubble), 32'd1);
    chk("reset_halted", 32'(is_halted), 32'd0);
    chk("reset_state_run", 32'(dbg_state), 32'(hazard_pkg::RUN));
    #2 reset_n = 1'b1;

    idle();
    chk("idle_pc_write", 32'(pc_write), 32'd1);

    // lw x5 in EX, add reading rs1=x5 in ID: one stall cycle.
    drive(5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
    // Load has moved to MEM; the add now passes.
    drive(5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0);
    chk("lu_after_pass", 32'(pc_write), 32'd1);

    // Destination x0 never stalls.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("lu_x0_no_stall", 32'(pc_write), 32'd1);
    // rs2 matches but is not read.
    drive(5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    chk("lu_rs2_unused", 32'(id_ex_bubble), 32'd0);
    // rs2 match that is read does stall.
    drive(5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    chk("lu_rs2_stall", 32'(if_id_write), 32'd0);

    // Mispredict together with a load-use: flush wins.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("misp_lu_pc_write", 32'(pc_write), 32'd1);
    chk("misp_lu_flush", 32'(if_id_flush), 32'd1);
    // Mispredict over a halting ecall: ecall ignored.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    // ecall without halt condition is an ordinary instruction.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("ecall_nohalt_pass", 32'(pc_write), 32'd1);

    // Halting ecall: accepted on the next edge, is_halted DC edges later.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("halt_accept_pc", 32'(pc_write), 32'd0);
    chk("halt_accept_flush", 32'(if_id_flush), 32'd1);
    idle();
    chk("drain1_halted", 32'(is_halted), 32'd0);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("drain2_misp_ignored", 32'(if_id_flush), 32'd0);
    idle();
    chk("drain3_halted", 32'(is_halted), 32'd0);
    idle();
    chk("halted_rise", 32'(is_halted), 32'd1);
    chk("halted_pc", 32'(pc_write), 32'd0);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    idle();
    chk("halted_sticky", 32'(is_halted), 32'd1);

    pulse_reset();
    // Reset in the second drain cycle returns to RUN with no leftover bubble.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();
    idle();
    reset_n = 1'b0;
    #1;
    chk("mid_drain_rst_state", 32'(dbg_state), 32'(hazard_pkg::RUN));
    chk("mid_drain_rst_pc", 32'(pc_write), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    idle();
    chk("post_rst_pc_write", 32'(pc_write), 32'd1);
    chk("post_rst_bubble", 32'(id_ex_bubble), 32'd0);
    chk("post_rst_halted", 32'(is_halted), 32'd0);

    // Long run of stalls to push the stall counter to saturation.
    for (int i = 0; i < 20; i++) begin
      drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    end
    idle();
`ifdef HAZARD_STATS_EN
    chk("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));
    chk("flush_after_reset", 32'(flush_cnt), 32'd0);
`endif
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
